// File: rtl/gray_arb_pkg.sv
// gray_arb_pkg
// Shared constants and types for the gray-memory read arbiter.
//   AW/DW     : address / pixel width of the 128x128 gray image
//   RSP_LAT   : fixed accept-to-response latency in cycles
//   arb_state_e : arbiter FSM states
//   next_ptr  : round-robin pointer advance helper
package gray_arb_pkg;

  localparam int AW      = 14;
  localparam int DW      = 8;
  localparam int IMG_W   = 128;
  localparam int IMG_H   = 128;
  localparam int RSP_LAT = 2;

  typedef enum logic [0:0] {
    WAIT_MEM = 1'b0,
    ARB      = 1'b1
  } arb_state_e;

  // Pointer after a grant to idx: the next requester, wrapping at nreq.
  function automatic int next_ptr(input int idx, input int nreq);
    if (idx + 1 >= nreq) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/gray_mem_arbiter_if.sv
// gray_mem_arbiter_if
// Bundles the requester-side handshake and the gray memory read port.
//   req_valid/req_addr/req_lock : requester beats (addr slice i = [i*AW +: AW])
//   req_ready                   : one-hot (or zero) beat acceptance
//   rsp_valid/rsp_data          : routed response, one-hot owner + shared data
//   gray_addr/gray_req          : registered memory read request
//   gray_ready/gray_data        : memory status and returned pixel
//   arb_idle                    : nothing pending, in flight or locked
// Modports: slave = arbiter side, master = requesters + memory side.
interface gray_mem_arbiter_if
  import gray_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = gray_arb_pkg::AW,
  parameter int DW   = gray_arb_pkg::DW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic [AW-1:0]      gray_addr;
  logic               gray_req;
  logic               gray_ready;
  logic [DW-1:0]      gray_data;
  logic               arb_idle;

  modport slave (
    input  req_valid, req_addr, req_lock, gray_ready, gray_data,
    output req_ready, rsp_valid, rsp_data, gray_addr, gray_req, arb_idle
  );

  modport master (
    output req_valid, req_addr, req_lock, gray_ready, gray_data,
    input  req_ready, rsp_valid, rsp_data, gray_addr, gray_req, arb_idle
  );

endinterface

// File: rtl/gray_mem_arbiter_rr_pick.sv
// rr_pick
// Purely combinational round-robin picker: scans req_i starting at ptr_i,
// wrapping mod NREQ, and returns the first set bit as a one-hot grant plus
// its encoded index. Zero grant when no request is set.
//   req_i   : request vector
//   ptr_i   : search start position
//   grant_o : one-hot grant (or zero)
//   idx_o   : encoded index of grant_o
module rr_pick
  import gray_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [PW-1:0]   idx_o
);

  logic found_s;

  function automatic int wrap_idx(input int v);
    if (v >= NREQ) begin
      return v - NREQ;
    end else begin
      return v;
    end
  endfunction

  // First requester at or after the pointer wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && req_i[wrap_idx(int'(ptr_i) + k)]) begin
        found_s                          = 1'b1;
        grant_o[wrap_idx(int'(ptr_i) + k)] = 1'b1;
        idx_o                            = PW'(wrap_idx(int'(ptr_i) + k));
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/gray_mem_arbiter.sv
// gray_mem_arbiter
// Shares one gray-image read port between NREQ requesters. One beat is
// granted per cycle, round-robin; the granted address is registered onto
// gray_addr/gray_req, memory answers one cycle later, and the response is
// steered back to its originator exactly 2 cycles after acceptance.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : gray_mem_arbiter_if.slave (requester handshake + memory port)
// Optional build macro GRAY_ARB_LOCK_EN: a requester may hold the grant
// across beats (req_lock) so a multi-beat window fetch stays contiguous.
// Without it req_lock is ignored.
module gray_mem_arbiter
  import gray_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = gray_arb_pkg::AW,
  parameter int DW   = gray_arb_pkg::DW
) (
  input  logic             clk,
  input  logic             reset,
  gray_mem_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q;
  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] id1_q;       // owner of the beat now on gray_addr
  logic [NREQ-1:0] rsp_valid_q; // owner of the data now on gray_data
  logic [AW-1:0]   gray_addr_q;
  logic            gray_req_q;

  logic [NREQ-1:0] eligible_s;
  logic [NREQ-1:0] pick_s;
  logic [PW-1:0]   pick_idx_s;
  logic            grant_en_s;
  logic            accept_s;
  logic [PW-1:0]   ptr_next_s;
  logic            lock_q;

`ifdef GRAY_ARB_LOCK_EN
  logic [PW-1:0] lock_owner_q;

  // Lock follows req_lock of every accepted beat; only the owner can be
  // accepted while locked, so this both sets, holds and releases it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q       <= 1'b0;
      lock_owner_q <= '0;
    end else if (accept_s) begin
      lock_q       <= bus.req_lock[pick_idx_s];
      lock_owner_q <= pick_idx_s;
    end else begin
      lock_q       <= lock_q;
      lock_owner_q <= lock_owner_q;
    end
  end

  // While locked, only the owner's request is visible to the picker.
  always_comb begin
    eligible_s = bus.req_valid;
    if (lock_q) begin
      eligible_s = bus.req_valid & (NREQ'(1) << lock_owner_q);
    end else begin
      eligible_s = bus.req_valid;
    end
  end
`else
  assign lock_q = 1'b0;

  // Every pending request competes.
  always_comb begin
    eligible_s = bus.req_valid;
  end
`endif

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req_i   (eligible_s),
    .ptr_i   (ptr_q),
    .grant_o (pick_s),
    .idx_o   (pick_idx_s)
  );

  // Grants are gated combinationally so a falling gray_ready stops them
  // in the same cycle, before the FSM has left ARB.
  assign grant_en_s    = (state_q == ARB) && bus.gray_ready;
  assign bus.req_ready = grant_en_s ? pick_s : '0;
  assign accept_s      = grant_en_s && (|pick_s);

  // Pointer after this cycle's grant. While locked the winner is always the
  // owner, so the pointer stays at owner+1, i.e. effectively frozen.
  always_comb begin
    ptr_next_s = PW'(next_ptr(int'(pick_idx_s), NREQ));
  end

  // FSM, memory request registers and 2-deep response-owner pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_MEM;
      ptr_q       <= '0;
      id1_q       <= '0;
      rsp_valid_q <= '0;
      gray_addr_q <= '0;
      gray_req_q  <= 1'b0;
    end else begin
      case (state_q)
        WAIT_MEM: state_q <= bus.gray_ready ? ARB : WAIT_MEM;
        ARB:      state_q <= bus.gray_ready ? ARB : WAIT_MEM;
        default:  state_q <= WAIT_MEM;
      endcase
      gray_req_q  <= accept_s;
      id1_q       <= accept_s ? pick_s : '0;
      rsp_valid_q <= id1_q;
      if (accept_s) begin
        gray_addr_q <= bus.req_addr[int'(pick_idx_s)*AW +: AW];
        ptr_q       <= ptr_next_s;
      end else begin
        gray_addr_q <= gray_addr_q;
        ptr_q       <= ptr_q;
      end
    end
  end

  assign bus.gray_addr = gray_addr_q;
  assign bus.gray_req  = gray_req_q;
  assign bus.rsp_valid = rsp_valid_q;
  // Memory data is already one cycle behind the request, so it lines up
  // with the second owner stage; forced to zero when nothing is returned.
  assign bus.rsp_data  = (|rsp_valid_q) ? bus.gray_data : '0;
  assign bus.arb_idle  = ~(|bus.req_valid) & ~(|id1_q) & ~(|rsp_valid_q) & ~lock_q;

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// tb_gray_mem_arbiter
// Directed bench for gray_mem_arbiter with a small gray memory model whose
// contents are mem_f(addr). Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge. Cycle c0 is the first cycle after
// reset release (FSM still in WAIT_MEM).
module tb_gray_mem_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 14;
  localparam int DW   = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  gray_mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  gray_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Memory model: data valid the cycle after the request.
  always @(posedge clk) begin
    if (bus.gray_req) bus.gray_data <= mem_f(bus.gray_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset          = 1'b1;
    bus.req_valid  = 2'b00;
    bus.req_lock   = 2'b00;
    bus.gray_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    reset          = 1'b1;
    bus.gray_ready = 1'b1;
    bus.req_valid  = 2'b11;
    bus.req_addr   = {14'd7, 14'd3};
    tick();
    tick();
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", bus.req_ready); end
    n_checks++; if (bus.gray_req !== 1'b0) begin n_fail++; $display("FAIL reset_greq got %b want 0", bus.gray_req); end
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rv got %b want 00", bus.rsp_valid); end
    n_checks++; if (bus.rsp_data !== 8'd0) begin n_fail++; $display("FAIL reset_rd got %h want 00", bus.rsp_data); end
    n_checks++; if (bus.gray_addr !== 14'd0) begin n_fail++; $display("FAIL reset_gaddr got %0d want 0", bus.gray_addr); end
    bus.req_valid = 2'b00;
    #1;
    n_checks++; if (bus.arb_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", bus.arb_idle); end
    tick();
    reset         = 1'b0;
    bus.req_valid = 2'b11;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rel_c0_ready got %b want 00", bus.req_ready); end
    tick();
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rel_c1_ready got %b want 01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
  endtask

  task automatic test_alternate();
    logic [1:0]    e_rdy, e_rv;
    logic          e_greq;
    logic [AW-1:0] e_gaddr;
    logic [DW-1:0] e_rd;
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_addr  = {14'd200, 14'd129};
    for (int c = 0; c < 10; c++) begin
      e_rdy   = (c == 0) ? 2'b00 : (((c - 1) % 2 == 0) ? 2'b01 : 2'b10);
      e_greq  = (c >= 2);
      e_gaddr = (c >= 2) ? (((c - 2) % 2 == 0) ? 14'd129 : 14'd200) : 14'd0;
      e_rv    = (c >= 3) ? (((c - 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      e_rd    = (c >= 3) ? mem_f(((c - 3) % 2 == 0) ? 14'd129 : 14'd200) : 8'd0;
      @(negedge clk);
      n_checks++; if (bus.req_ready !== e_rdy) begin n_fail++; $display("FAIL alt_ready c%0d got %b want %b", c, bus.req_ready, e_rdy); end
      n_checks++; if (bus.gray_req !== e_greq) begin n_fail++; $display("FAIL alt_greq c%0d got %b want %b", c, bus.gray_req, e_greq); end
      n_checks++; if (bus.gray_addr !== e_gaddr) begin n_fail++; $display("FAIL alt_gaddr c%0d got %0d want %0d", c, bus.gray_addr, e_gaddr); end
      n_checks++; if (bus.rsp_valid !== e_rv) begin n_fail++; $display("FAIL alt_rv c%0d got %b want %b", c, bus.rsp_valid, e_rv); end
      n_checks++; if (bus.rsp_data !== e_rd) begin n_fail++; $display("FAIL alt_rd c%0d got %h want %h", c, bus.rsp_data, e_rd); end
      tick();
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_mem_stall();
    // Expectations for cycles c5..c12; gray_ready low in c5..c8.
    logic [1:0]    e_rdy [0:7];
    logic          e_greq[0:7];
    logic [1:0]    e_rv  [0:7];
    logic [DW-1:0] e_rd  [0:7];
    e_rdy  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
    e_greq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    e_rv   = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    e_rd   = '{8'h24, 8'h6D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h24};
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_addr  = {14'd200, 14'd129};
    for (int c = 0; c < 13; c++) begin
      bus.gray_ready = !(c >= 5 && c <= 8);
      @(negedge clk);
      if (c >= 5) begin
        n_checks++; if (bus.req_ready !== e_rdy[c-5]) begin n_fail++; $display("FAIL stall_ready c%0d got %b want %b", c, bus.req_ready, e_rdy[c-5]); end
        n_checks++; if (bus.gray_req !== e_greq[c-5]) begin n_fail++; $display("FAIL stall_greq c%0d got %b want %b", c, bus.gray_req, e_greq[c-5]); end
        n_checks++; if (bus.rsp_valid !== e_rv[c-5]) begin n_fail++; $display("FAIL stall_rv c%0d got %b want %b", c, bus.rsp_valid, e_rv[c-5]); end
        n_checks++; if (bus.rsp_data !== e_rd[c-5]) begin n_fail++; $display("FAIL stall_rd c%0d got %h want %h", c, bus.rsp_data, e_rd[c-5]); end
      end
      tick();
    end
    bus.req_valid  = 2'b00;
    bus.gray_ready = 1'b1;
  endtask

  task automatic test_single();
    logic [1:0]    e_rdy, e_rv;
    logic          e_greq;
    logic [AW-1:0] e_gaddr;
    logic [DW-1:0] e_rd;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      bus.req_valid = (c >= 1 && c <= 10) ? 2'b10 : 2'b00;
      bus.req_addr  = {14'((c >= 1) ? c - 1 : 0), 14'd77};
      e_rdy   = (c >= 1 && c <= 10) ? 2'b10 : 2'b00;
      e_greq  = (c >= 2 && c <= 11);
      e_gaddr = (c < 2) ? 14'd0 : ((c - 2 > 9) ? 14'd9 : 14'(c - 2));
      e_rv    = (c >= 3 && c <= 12) ? 2'b10 : 2'b00;
      e_rd    = (c >= 3 && c <= 12) ? mem_f(14'(c - 3)) : 8'd0;
      @(negedge clk);
      n_checks++; if (bus.req_ready !== e_rdy) begin n_fail++; $display("FAIL single_ready c%0d got %b want %b", c, bus.req_ready, e_rdy); end
      n_checks++; if (bus.gray_req !== e_greq) begin n_fail++; $display("FAIL single_greq c%0d got %b want %b", c, bus.gray_req, e_greq); end
      n_checks++; if (bus.gray_addr !== e_gaddr) begin n_fail++; $display("FAIL single_gaddr c%0d got %0d want %0d", c, bus.gray_addr, e_gaddr); end
      n_checks++; if (bus.rsp_valid !== e_rv) begin n_fail++; $display("FAIL single_rv c%0d got %b want %b", c, bus.rsp_valid, e_rv); end
      n_checks++; if (bus.rsp_data !== e_rd) begin n_fail++; $display("FAIL single_rd c%0d got %h want %h", c, bus.rsp_data, e_rd); end
      if (c == 13) begin
        n_checks++; if (bus.arb_idle !== 1'b1) begin n_fail++; $display("FAIL single_idle got %b want 1", bus.arb_idle); end
      end
      tick();
    end
  endtask

  task automatic test_lock();
    // Requester 0: valid c1..c4 and c6..c10 (bubble at c5), lock on all
    // but the c10 beat. Requester 1 valid throughout.
    logic [1:0] e_rdy[0:12];
`ifdef GRAY_ARB_LOCK_EN
    e_rdy = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01,
              2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
`else
    e_rdy = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01,
              2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
`endif
    do_reset();
    bus.req_addr = {14'd500, 14'd300};
    for (int c = 0; c < 13; c++) begin
      bus.req_valid[0] = (c >= 1 && c <= 4) || (c >= 6 && c <= 10);
      bus.req_valid[1] = 1'b1;
      bus.req_lock[0]  = (c >= 1 && c <= 9);
      bus.req_lock[1]  = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.req_ready !== e_rdy[c]) begin n_fail++; $display("FAIL lock_ready c%0d got %b want %b", c, bus.req_ready, e_rdy[c]); end
      tick();
    end
    bus.req_valid = 2'b00;
    bus.req_lock  = 2'b00;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_lock  = 2'b01;
    bus.req_addr  = {14'd20, 14'd10};
    tick();  // c1: accept
    tick();  // c2: accept
    reset         = 1'b1;  // c3: two beats in flight
    bus.req_valid = 2'b00;
    bus.req_lock  = 2'b00;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL inflight_rv_rst got %b want 00", bus.rsp_valid); end
    n_checks++; if (bus.gray_req !== 1'b0) begin n_fail++; $display("FAIL inflight_greq_rst got %b want 0", bus.gray_req); end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL inflight_rv c%0d got %b want 00", c, bus.rsp_valid); end
      n_checks++; if (bus.arb_idle !== 1'b1) begin n_fail++; $display("FAIL inflight_idle c%0d got %b want 1", c, bus.arb_idle); end
      tick();
    end
    // Any lock from before reset must be gone: requester 1 is granted.
    bus.req_valid = 2'b10;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL inflight_unlock got %b want 10", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.req_valid  = 2'b00;
    bus.req_addr   = '0;
    bus.req_lock   = 2'b00;
    bus.gray_ready = 1'b1;
    bus.gray_data  = 8'd0;
    test_reset();
    test_alternate();
    test_mem_stall();
    test_single();
    test_lock();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
